// File: rtl/acc_decimator.sv
// acc_decimator: boxcar integrate-and-dump decimator.
// Sums 2^ratio_log2 qualified signed samples, arithmetic-shifts the window sum
// right by `shift` and emits one wide word per completed window.
//
// Handshake: in_valid qualifies `in` on every rising clk edge. There is no
// backpressure, so every qualified sample is consumed. out_valid is a one-cycle
// registered pulse, and `out` changes only in the cycle out_valid is high.
module acc_decimator #(
  parameter int R         = 14,
  parameter int NMAX_LOG2 = 10,
  parameter int RO        = R + NMAX_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [3:0]           ratio_log2,
  input  logic [3:0]           shift,
  input  logic signed [R-1:0]  in,
  input  logic                 in_valid,
  output logic signed [RO-1:0] out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 o_dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  // The counter must reach 2^NMAX_LOG2, which needs one bit more than the exponent.
  localparam int         CW     = NMAX_LOG2 + 1;
  localparam logic [3:0] NMAX_L = 4'(NMAX_LOG2);

  state_t                r_state;
  logic signed [RO-1:0]  r_acc;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_ratio;
  logic [3:0]            r_shift;
  logic signed [RO-1:0]  r_out;
  logic                  r_out_valid;

  logic [3:0]            w_ratio_c;
  logic [3:0]            w_shift_c;
  logic                  w_run;
  logic                  w_start;
  logic [3:0]            w_ratio_eff;
  logic [3:0]            w_shift_eff;
  logic signed [RO-1:0]  w_in_ext;
  logic signed [RO-1:0]  w_sum;
  logic [CW-1:0]         w_cnt_next;
  logic [CW-1:0]         w_target;
  logic                  w_done;

  // Window arithmetic. A window starts on the first sample after IDLE or after a
  // completion (cnt==0). A starting sample uses the freshly clamped settings;
  // later samples use the latched ones.
  always_comb begin
    w_ratio_c   = (ratio_log2 > NMAX_L) ? NMAX_L : ratio_log2;
    w_shift_c   = (shift > NMAX_L) ? NMAX_L : shift;
    w_run       = enable & ~clear;
    w_start     = (r_state == IDLE) || (r_cnt == '0);
    w_ratio_eff = w_start ? w_ratio_c : r_ratio;
    w_shift_eff = w_start ? w_shift_c : r_shift;
    w_in_ext    = {{(RO-R){in[R-1]}}, in};
    w_sum       = w_start ? w_in_ext : (r_acc + w_in_ext);
    w_cnt_next  = w_start ? CW'(1) : (r_cnt + CW'(1));
    w_target    = CW'(1) << w_ratio_eff;
    w_done      = (w_cnt_next == w_target);
  end

  // Control FSM and datapath. enable=0 or clear=1 discards the partial window,
  // drops the coincident sample and suppresses any coincident completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ratio     <= '0;
      r_shift     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (!w_run) begin
        r_state <= IDLE;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (in_valid) begin
        r_state <= ACC;
        if (w_start) begin
          r_ratio <= w_ratio_c;
          r_shift <= w_shift_c;
        end
        if (w_done) begin
          r_out       <= w_sum >>> w_shift_eff;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_next;
        end
      end
    end
  end

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state == ACC) && (r_cnt != '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_acc_decimator.sv
// tb_acc_decimator: directed stimulus with a queue-based scoreboard for acc_decimator.
module tb_acc_decimator;

  localparam int R  = 14;
  localparam int NL = 10;
  localparam int RO = R + NL;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic                 clear;
  logic [3:0]           ratio_log2;
  logic [3:0]           shift;
  logic signed [R-1:0]  in;
  logic                 in_valid;
  logic signed [RO-1:0] out;
  logic                 out_valid;
  logic                 busy;
  logic                 dbg_state;

  int total = 0;
  int bad   = 0;
  int pushed = 0;
  int popped = 0;
  logic [RO-1:0] exp_q[$];

  acc_decimator #(.R(R), .NMAX_LOG2(NL), .RO(RO)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .ratio_log2 (ratio_log2),
    .shift      (shift),
    .in         (in),
    .in_valid   (in_valid),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in       = R'(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push(input int v);
    exp_q.push_back(RO'(v));
    pushed++;
  endtask

  // monitor: every out_valid pulse is matched against the scoreboard head
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got out=%0d with empty expected queue", out);
      end else begin
        logic [RO-1:0] e;
        e = exp_q.pop_front();
        popped++;
        chk("scoreboard_out", out, $signed(e));
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; ratio_log2 = 4'd0; shift = 4'd0;
    in = '0; in_valid = 1'b0;
    repeat (3) step();
    chk("reset_out", out, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;
    enable = 1'b1;
    step();

    // window of 4 with gaps: (100+200+300+400)>>>2 = 250
    ratio_log2 = 4'd2; shift = 4'd2;
    push(250);
    send(100); step();
    chk("busy_mid_window", busy, 1);
    send(200); step(); step();
    send(300);
    send(400);
    chk("pulse_one_clk_after_4th", out_valid, 1);
    chk("busy_after_completion", busy, 0);
    step();
    chk("pulse_one_cycle", out_valid, 0);
    chk("out_held", out, 250);

    // asynchronous reset mid-window, checked between clock edges
    send(11); send(12);
    chk("busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_valid", out_valid, 0);
    #1 rst = 1'b0;
    step();

    // full 1024-sample windows at both extremes
    ratio_log2 = 4'd10; shift = 4'd0;
    push(-8388608);
    for (int i = 0; i < 1024; i++) send(-8192);
    push(8387584);
    for (int i = 0; i < 1024; i++) send(8191);
    step();

    // ratio 0, continuous valid
    ratio_log2 = 4'd0; shift = 4'd0;
    push(-5); push(7);
    in = -14'sd5; in_valid = 1'b1; step();
    chk("cont_valid_first", out_valid, 1);
    in = 14'sd7; step();
    chk("cont_valid_second", out_valid, 1);
    in_valid = 1'b0; step();
    chk("cont_valid_drop", out_valid, 0);

    // shift clamps to 10: -8192>>>10 = -8 (an unclamped 15 would give -1)
    shift = 4'd15;
    push(-8);
    send(-8192); step();

    // enable=0 drops the sample; no pulse, out held
    enable = 1'b0;
    send(33);
    chk("disabled_no_pulse", out_valid, 0);
    chk("disabled_out_held", out, -8);
    enable = 1'b1;

    // completion coinciding with clear is suppressed
    ratio_log2 = 4'd1; shift = 4'd0;
    send(5);
    clear = 1'b1; send(6); clear = 1'b0;
    chk("clear_suppress", out_valid, 0);

    // clear mid-window discards partial sum and the coincident sample
    ratio_log2 = 4'd2; shift = 4'd1;
    send(50); send(50);
    clear = 1'b1; send(999); clear = 1'b0;
    chk("busy_after_clear", busy, 0);
    push(2);
    for (int i = 0; i < 4; i++) send(1);
    step();

    // ratio change mid-window takes effect at the next window
    ratio_log2 = 4'd2; shift = 4'd0;
    push(10);
    send(1);
    ratio_log2 = 4'd3;
    send(2); send(3); send(4);
    push(36);
    for (int i = 1; i <= 8; i++) send(i);
    repeat (3) step();

    chk("queue_drained", exp_q.size(), 0);
    chk("pulse_count", popped, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
